// File: rtl/conv_mac_sequencer_if.sv
// Bundles the sample-RAM read ports and the result stream of conv_mac_sequencer.
// master: sequencer side (drives RAM reads and results, receives RAM data and res_ready).
// slave: consumer/RAM side (the mirror image of master).
interface conv_mac_sequencer_if #(
  parameter int AW   = 5,
  parameter int DW   = 21,
  parameter int IW   = 6,
  parameter int ACCW = 47
);
  logic            a_rd;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_data;
  logic            b_rd;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   b_data;
  logic            res_valid;
  logic            res_ready;
  logic [IW-1:0]   res_idx;
  logic [ACCW-1:0] res_data;

  modport master (
    output a_rd, a_addr, input a_data,
    output b_rd, b_addr, input b_data,
    output res_valid, res_idx, res_data, input res_ready
  );

  modport slave (
    input a_rd, a_addr, output a_data,
    input b_rd, b_addr, output b_data,
    input res_valid, res_idx, res_data, output res_ready
  );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Sequences one multiply-accumulate datapath over two N-sample RAMs to produce the
// 2N-1 point linear convolution y[k] = sum a[i]*b[k-i], streamed out on valid/ready.
// Ports: clk/rst (async, active-high), start/abort control, busy/done status,
// bus (master modport): RAM A/B read strobes, addresses and data, result stream.
// Latency: T_k+3 cycles per output with res_ready high (T_k = terms of output k).
// Backpressure: res_ready low holds the result in OUT indefinitely; no reads meanwhile.
// Build option: define CONV_MAC_SIGNED_EN for two's-complement operands and results.
module conv_mac_sequencer #(
  parameter int N    = 21,
  parameter int DW   = 21,
  parameter int AW   = 5,
  parameter int IW   = 6,
  parameter int ACCW = 47
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  conv_mac_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [IW-1:0] K_LAST = IW'(2 * N - 2);

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     k;
  logic [AW-1:0]     i;
  logic [ACCW-1:0]   acc;
  logic              rd_vld;      // a read was issued last cycle, RAM data valid now
  logic              prod_vld;    // prod holds a term to accumulate this cycle
  logic [2*DW-1:0]   prod;
  logic [2*DW-1:0]   prod_nxt;
  logic [ACCW-1:0]   prod_ext;
  logic              wait_cnt;
  logic              done_q;
  logic              hs;
  logic              last_hs;
  logic [AW-1:0]     i_hi;
  logic [IW-1:0]     k_inc;

  // First and last valid i for output k: i ranges over max(0,k-N+1)..min(k,N-1).
  function automatic logic [AW-1:0] lo_of(input logic [IW-1:0] kk);
    if (kk >= IW'(N)) lo_of = AW'(kk - IW'(N - 1));
    else              lo_of = '0;
  endfunction

  function automatic logic [AW-1:0] hi_of(input logic [IW-1:0] kk);
    if (kk < IW'(N)) hi_of = AW'(kk);
    else             hi_of = AW'(N - 1);
  endfunction

  assign i_hi    = hi_of(k);
  assign k_inc   = k + IW'(1);
  assign hs      = (state == S_OUT) && bus.res_ready;
  assign last_hs = hs && (k == K_LAST);

`ifdef CONV_MAC_SIGNED_EN
  assign prod_nxt = (2*DW)'($signed(bus.a_data)) * (2*DW)'($signed(bus.b_data));
  assign prod_ext = ACCW'($signed(prod));
`else
  assign prod_nxt = (2*DW)'(bus.a_data) * (2*DW)'(bus.b_data);
  assign prod_ext = ACCW'(prod);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides everything, including a start in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (i == i_hi) state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt) state_nxt = S_OUT;
      S_OUT:   if (hs) state_nxt = (k == K_LAST) ? S_IDLE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Outputs: decoded from state; result fields forced to 0 outside OUT.
  always_comb begin
    busy          = (state != S_IDLE);
    done          = done_q;
    bus.a_rd      = 1'b0;
    bus.b_rd      = 1'b0;
    bus.a_addr    = '0;
    bus.b_addr    = '0;
    bus.res_valid = 1'b0;
    bus.res_idx   = '0;
    bus.res_data  = '0;
    if (state == S_ISSUE) begin
      bus.a_rd   = 1'b1;
      bus.b_rd   = 1'b1;
      bus.a_addr = i;
      bus.b_addr = AW'(k - IW'(i));
    end
    if (state == S_OUT) begin
      bus.res_valid = 1'b1;
      bus.res_idx   = k;
      bus.res_data  = acc;
    end
  end

  // Datapath: read -> product register -> accumulate. Counters k/i follow the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      i        <= '0;
      acc      <= '0;
      rd_vld   <= 1'b0;
      prod_vld <= 1'b0;
      prod     <= '0;
      wait_cnt <= 1'b0;
      done_q   <= 1'b0;
    end else if (abort) begin
      // In-flight terms are dropped and no done pulse is produced.
      k        <= '0;
      i        <= '0;
      acc      <= '0;
      rd_vld   <= 1'b0;
      prod_vld <= 1'b0;
      wait_cnt <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_vld   <= (state == S_ISSUE);
      prod_vld <= rd_vld;
      if (rd_vld) prod <= prod_nxt;
      if (prod_vld) acc <= acc + prod_ext;
      done_q   <= last_hs;

      case (state)
        S_IDLE: begin
          if (start) begin
            k   <= '0;
            i   <= '0;
            acc <= '0;
          end
        end
        S_ISSUE: begin
          if (i != i_hi) i <= i + AW'(1);
          wait_cnt <= 1'b0;
        end
        S_WAIT: begin
          wait_cnt <= ~wait_cnt;
        end
        S_OUT: begin
          if (hs) begin
            if (k == K_LAST) begin
              k   <= '0;
              i   <= '0;
              acc <= '0;
            end else begin
              k   <= k_inc;
              i   <= lo_of(k_inc);
              acc <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Randomized scoreboard bench for conv_mac_sequencer at N=4, DW=8.
// Reference: direct double sum over all (i,j) pairs into y[i+j].
module tb_conv_mac_sequencer;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int IW   = 3;
  localparam int ACCW = 18;
  localparam int LAT  = N * N + 3 * (2 * N - 1);
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  conv_mac_sequencer_if #(.AW(AW), .DW(DW), .IW(IW), .ACCW(ACCW)) bus ();

  conv_mac_sequencer #(.N(N), .DW(DW), .AW(AW), .IW(IW), .ACCW(ACCW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Sample RAMs with one cycle read latency
  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  logic [DW-1:0] a_q = '0;
  logic [DW-1:0] b_q = '0;
  always @(posedge clk) begin
    if (bus.a_rd) a_q <= mem_a[bus.a_addr];
    if (bus.b_rd) b_q <= mem_b[bus.b_addr];
  end
  assign bus.a_data = a_q;
  assign bus.b_data = b_q;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int rdy_mode = 0;

  typedef struct {
    int              idx;
    logic [ACCW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint sval(input logic [DW-1:0] x);
`ifdef CONV_MAC_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  task automatic push_expected();
    longint y [2*N-1];
    exp_t e;
    for (int k = 0; k < 2 * N - 1; k++) y[k] = 0;
    for (int ia = 0; ia < N; ia++)
      for (int jb = 0; jb < N; jb++)
        y[ia + jb] += sval(mem_a[ia]) * sval(mem_b[jb]);
    for (int k = 0; k < 2 * N - 1; k++) begin
      e.idx  = k;
      e.data = ACCW'(y[k]);
      exp_q.push_back(e);
    end
  endtask

  // res_ready driver: 0 = always high, 1 = high one cycle in three, 2 = random
  initial begin
    int phase = 0;
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.res_ready = 1'b1;
        1: bus.res_ready = (phase == 0);
        default: bus.res_ready = 1'($urandom_range(0, 1));
      endcase
      phase = (phase + 1) % 3;
    end
  end

  // Monitor: pops the scoreboard on every result handshake
  initial begin
    bit              pv = 1'b0;
    bit              pr = 1'b0;
    logic [IW-1:0]   pi = '0;
    logic [ACCW-1:0] pd = '0;
    exp_t            e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (bus.res_valid) chk("no_read_in_out", {62'd0, bus.a_rd, bus.b_rd}, 64'd0);
        if (pv && !pr && bus.res_valid) begin
          chk("hold_idx", 64'(bus.res_idx), 64'(pi));
          chk("hold_data", 64'(bus.res_data), 64'(pd));
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result idx=%0d data=%0d", bus.res_idx, bus.res_data);
          end else begin
            e = exp_q.pop_front();
            chk("res_idx", 64'(bus.res_idx), 64'(e.idx));
            chk("res_data", 64'(bus.res_data), 64'(e.data));
          end
        end
        if (done) done_cnt++;
        pv = bus.res_valid;
        pr = bus.res_ready;
        pi = bus.res_idx;
        pd = bus.res_data;
      end
    end
  end

  // One convolution run. Called at negedge+1 with the DUT idle.
  task automatic run(input int mode, input bit inject, input bit do_abort, input bit chk_lat);
    int  n;
    bit  fin = 1'b0;
    bit  injected = 1'b0;
    rdy_mode = mode;
    push_expected();
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (n <= LIMIT) begin
      start = 1'b0;
      if (do_abort && bus.a_rd && bus.a_addr == AW'(2) && bus.b_addr == AW'(0)) begin
        abort = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_res_valid", 64'(bus.res_valid), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        return;
      end
      if (bus.res_valid && bus.res_ready && bus.res_idx == IW'(2 * N - 2)) begin
        fin = 1'b1;
        break;
      end
      if (inject && !injected && bus.res_valid) begin
        start = 1'b1;
        injected = 1'b1;
      end
      @(negedge clk);
      #1;
      n++;
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=%0d required<=%0d", n, LIMIT);
      abort = 1'b1;
      @(negedge clk);
      #1;
      abort = 1'b0;
      exp_q.delete();
      return;
    end
    if (chk_lat) chk("latency", 64'(n), 64'(LAT));
    @(negedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    exp_done++;
    @(negedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    for (int j = 0; j < N; j++) begin
      mem_a[j] = '0;
      mem_b[j] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_rd", 64'({bus.a_rd, bus.b_rd}), 64'd0);
    chk("idle_res", 64'({bus.res_valid, bus.res_idx, bus.res_data}), 64'd0);

    // ramp against ones, ready high, latency
    for (int j = 0; j < N; j++) begin
      mem_a[j] = DW'(j + 1);
      mem_b[j] = DW'(1);
    end
    run(0, 1'b0, 1'b0, 1'b1);

    // same data with 1-in-3 ready and a start pulse while in OUT
    run(1, 1'b1, 1'b0, 1'b0);

    // full-scale operands
    for (int j = 0; j < N; j++) begin
      mem_a[j] = '1;
      mem_b[j] = '1;
    end
    run(0, 1'b0, 1'b0, 1'b1);

    // abort in the third ISSUE cycle of k=2
    for (int j = 0; j < N; j++) begin
      mem_a[j] = DW'($urandom_range(0, 255));
      mem_b[j] = DW'($urandom_range(0, 255));
    end
    run(0, 1'b0, 1'b1, 1'b0);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 64'(busy), 64'd0);
    @(negedge clk);
    #1;
    run(0, 1'b0, 1'b0, 1'b1);

    // sign-sensitive pattern
    mem_a[0] = 8'hFF; mem_a[1] = 8'h02; mem_a[2] = 8'h00; mem_a[3] = 8'h00;
    mem_b[0] = 8'h03; mem_b[1] = 8'h00; mem_b[2] = 8'h00; mem_b[3] = 8'h00;
    run(0, 1'b0, 1'b0, 1'b1);

    // random data with random backpressure
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < N; j++) begin
        mem_a[j] = DW'($urandom_range(0, 255));
        mem_b[j] = DW'($urandom_range(0, 255));
      end
      run(2, (r % 2) == 1, 1'b0, 1'b0);
    end

    repeat (2) @(negedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 64'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_mac_sequencer.md
Name: conv_mac_sequencer

Overview:
- Controller that time-multiplexes one multiply-accumulate datapath to compute the full linear convolution of two N-sample sequences.
- Both sequences sit in external single-port sample RAMs with 1-cycle read latency.
- Drives the RAM read addresses and the MAC pipeline, then streams 2N-1 results out over a valid/ready interface.
- Sits between the sample buffers and the downstream result consumer. Replaces the fully parallel convolution array where area matters.

Parameters:
- N, 21, samples per input sequence (N >= 2).
- DW, 21, bits per input sample.
- AW, 5, sample address width; must satisfy 2^AW >= N.
- IW, 6, result index width; must satisfy 2^IW >= 2N-1.
- ACCW, 47, accumulator/result width; must be >= 2*DW + ceil(log2 N).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a convolution; honoured only in IDLE.
- abort  in  1  synchronous abort; forces IDLE next cycle from any state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final result handshake.
- a_rd  out  1  read strobe to sample RAM A.
- a_addr  out  AW  read address to RAM A.
- a_data  in  DW  RAM A data, valid the cycle after a_rd.
- b_rd  out  1  read strobe to sample RAM B.
- b_addr  out  AW  read address to RAM B.
- b_data  in  DW  RAM B data, valid the cycle after b_rd.
- res_valid  out  1  result k is presented.
- res_ready  in  1  consumer accepts the result when high with res_valid.
- res_idx  out  IW  output index k, range 0..2N-2.
- res_data  out  ACCW  y[k] = sum over i of a[i]*b[k-i], for i = max(0,k-N+1)..min(k,N-1).

Behaviour:
- Reset values: all outputs 0, state IDLE, k=0, i=0, accumulator 0, pipeline valid bits 0.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - start=1 -> ISSUE, with k=0, i=lo(0), accumulator cleared.
  - start=0 -> remain in IDLE.
- ISSUE: one term per cycle.
  - a_rd=b_rd=1, a_addr=i, b_addr=k-i.
  - When i==hi(k), go to WAIT; otherwise increment i.
  - Term count T_k = hi-lo+1, so ISSUE lasts T_k cycles.
- Datapath pipeline:
  - Stage 1: RAM read.
  - Stage 2: product register, a_data*b_data, 2*DW bits.
  - Accumulate on the edge where the product-valid bit is set.
  - Product is zero-extended to ACCW (see the optional feature for signed mode).
- WAIT: exactly 2 cycles, draining the pipeline; no reads. Then go to OUT.
- OUT:
  - res_valid=1; res_idx=k and res_data=accumulator, both held stable until the handshake.
  - On res_valid & res_ready:
    - k==2N-2: go to IDLE and pulse done in the first IDLE cycle.
    - Otherwise: k++, i=lo(k+1), clear accumulator, go to ISSUE.
- Latency with res_ready tied high:
  - Each output takes T_k+3 cycles.
  - Total from the cycle after start to the final handshake: N^2 + 3(2N-1) cycles.
- Boundary and simultaneous-event rules:
  - start while busy: ignored, no effect.
  - abort (any state): next cycle is IDLE, res_valid=0, no done pulse, in-flight products discarded.
  - abort and start asserted together in IDLE: abort wins, stay in IDLE.
  - res_ready low in OUT: stall indefinitely; no RAM reads issued while stalled.
  - rst mid-operation: immediate return to reset values, no done pulse.
  - k=0 and k=2N-2: single-term outputs, T=1, a_addr/b_addr 0/0 and N-1/N-1 respectively.
  - Addresses never exceed N-1; a_rd/b_rd are low outside ISSUE.

Optional Feature:
- Macro: CONV_MAC_SIGNED_EN.
- Defined: a_data, b_data and res_data are two's complement; the product is computed signed and sign-extended to ACCW before accumulation.
- Undefined: all operands unsigned; the product is zero-extended.
- Port list, state machine and timing are identical in both builds.

Test Plan:
- N=4, DW=8, a=[1,2,3,4], b=[1,1,1,1], res_ready=1 -> res_idx 0..6 with res_data 1,3,6,10,9,7,4; done pulses once; 37 cycles from the cycle after start to the last handshake.
- Same stimulus, res_ready toggling 1-of-3 cycles -> identical result sequence; res_idx/res_data stable while stalled; no a_rd/b_rd during stalls.
- N=4, DW=8, a=b=[255,255,255,255] -> y[3]=260100 with no overflow (ACCW=18); y[0]=65025.
- abort asserted in the third ISSUE cycle of k=2 -> IDLE next cycle, busy=0, res_valid=0, no done; a following start gives the full correct sequence from k=0.
- start pulsed during OUT, and start with abort together in IDLE -> both ignored; run completes unchanged.
- CONV_MAC_SIGNED_EN defined, a=[-1,2,0,0] (0xFF,0x02), b=[3,0,0,0] -> y[0]=-3, y[1]=6; without the macro -> y[0]=765, y[1]=6.
